// File: rtl/conv_padding_p_if.sv
// Pixel stream bundle between the frame source/sink and conv_padding_p.
// With CONV_PAD_SYNC_EN defined the bundle also carries o_sof/o_eol/o_eof.
interface conv_padding_p_if #(
  parameter int DW = 16,
  parameter int SW = 11
);
  logic signed [DW-1:0] i_data;
  logic                 i_valid;
  logic [SW-1:0]        image_size;
  logic signed [DW-1:0] pad_value;
  logic signed [DW-1:0] o_data;
  logic                 o_valid;
  logic                 o_busy;
  logic                 o_err;
`ifdef CONV_PAD_SYNC_EN
  logic                 o_sof;
  logic                 o_eol;
  logic                 o_eof;

  modport master (output i_data, i_valid, image_size, pad_value,
                  input  o_data, o_valid, o_busy, o_err, o_sof, o_eol, o_eof);
  modport slave  (input  i_data, i_valid, image_size, pad_value,
                  output o_data, o_valid, o_busy, o_err, o_sof, o_eol, o_eof);
`else
  modport master (output i_data, i_valid, image_size, pad_value,
                  input  o_data, o_valid, o_busy, o_err);
  modport slave  (input  i_data, i_valid, image_size, pad_value,
                  output o_data, o_valid, o_busy, o_err);
`endif
endinterface

// File: rtl/conv_padding_p.sv
// Border-padding stage: wraps an N x N raster frame in a PAD-wide border of a runtime value.
// Defining CONV_PAD_SYNC_EN adds o_sof/o_eol/o_eof frame markers aligned with o_valid.
module conv_padding_p #(
  parameter int DW      = 16,
  parameter int SW      = 11,
  parameter int PAD     = 1,
  parameter int FIFO_AW = 11
) (
  input  logic            p_clk,
  input  logic            rst_n,
  conv_padding_p_if.slave bus
);
  // state   | meaning
  // ST_IDLE | waiting for a frame start, counters held at 0
  // ST_RUN  | scanning output positions (vcnt, hcnt) over the M x M frame
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam int               DEPTH    = 1 << FIFO_AW;
  localparam logic [SW-1:0]    PAD_W    = SW'(PAD);
  localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW+1)'(DEPTH);

  logic [0:0]           state_q, state_d;
  logic [SW-1:0]        hcnt_q, hcnt_d, vcnt_q, vcnt_d;
  logic [SW-1:0]        n_q, n_d, m_q, m_d;
  logic [2*SW-1:0]      nsq_q, nsq_d, acc_q, acc_d;
  logic signed [DW-1:0] pad_q, pad_d;
  logic                 err_q, err_d;
  logic                 o_valid_q, o_valid_d;
  logic signed [DW-1:0] o_data_q, o_data_d;

  logic signed [DW-1:0] mem_q [DEPTH];
  logic [FIFO_AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]     cnt_q, cnt_d;

  logic          run, last_col, last_pos, start, border, interior;
  logic          fifo_empty, fifo_full, in_frame, accept, drop;
  logic          wr_en, rd_en, overflow, underflow;
  logic [SW-1:0] m_last, pad_hi;

  always_comb begin
    run        = (state_q == ST_RUN);
    m_last     = m_q - SW'(1);
    pad_hi     = n_q + PAD_W;
    last_col   = run && (hcnt_q == m_last);
    last_pos   = last_col && (vcnt_q == m_last);
    border     = (vcnt_q < PAD_W) || (vcnt_q >= pad_hi) ||
                 (hcnt_q < PAD_W) || (hcnt_q >= pad_hi);
    interior   = run && !border;
    fifo_empty = (cnt_q == '0);
    fifo_full  = (cnt_q == FULL_CNT);
    // The final RUN cycle already takes a start word so chained frames leave no output gap.
    start      = bus.i_valid && (bus.image_size != '0) && (!run || last_pos);
    in_frame   = bus.i_valid && run && !last_pos;
    accept     = in_frame && (acc_q < nsq_q);
    drop       = in_frame && (acc_q >= nsq_q);
    overflow   = accept && fifo_full;
    wr_en      = start || (accept && !fifo_full);
    rd_en      = interior && !fifo_empty;
    underflow  = interior && fifo_empty;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (start || last_pos) begin
      rd_ptr_d = wr_ptr_q;
      cnt_d    = '0;
    end else if (rd_en) begin
      rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
      cnt_d    = cnt_q - (FIFO_AW+1)'(1);
    end
    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + FIFO_AW'(1);
      cnt_d    = cnt_d + (FIFO_AW+1)'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    vcnt_d  = vcnt_q;
    n_d     = n_q;
    m_d     = m_q;
    nsq_d   = nsq_q;
    pad_d   = pad_q;
    acc_d   = acc_q;
    err_d   = err_q | underflow | drop | overflow;
    if (run) begin
      if (last_pos) begin
        state_d = ST_IDLE;
        hcnt_d  = '0;
        vcnt_d  = '0;
      end else if (last_col) begin
        hcnt_d = '0;
        vcnt_d = vcnt_q + SW'(1);
      end else begin
        hcnt_d = hcnt_q + SW'(1);
      end
    end
    if (accept) acc_d = acc_q + (2*SW)'(1);
    if (start) begin
      state_d = ST_RUN;
      hcnt_d  = '0;
      vcnt_d  = '0;
      n_d     = bus.image_size;
      m_d     = bus.image_size + SW'(2 * PAD);
      nsq_d   = (2*SW)'(bus.image_size) * (2*SW)'(bus.image_size);
      pad_d   = bus.pad_value;
      acc_d   = (2*SW)'(1);
    end
    o_valid_d = run;
    o_data_d  = '0;
    if (run) o_data_d = border ? pad_q : (fifo_empty ? '0 : mem_q[rd_ptr_q]);
  end

  always_ff @(posedge p_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      hcnt_q    <= '0;
      vcnt_q    <= '0;
      n_q       <= '0;
      m_q       <= '0;
      nsq_q     <= '0;
      acc_q     <= '0;
      pad_q     <= '0;
      err_q     <= 1'b0;
      o_valid_q <= 1'b0;
      o_data_q  <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      hcnt_q    <= hcnt_d;
      vcnt_q    <= vcnt_d;
      n_q       <= n_d;
      m_q       <= m_d;
      nsq_q     <= nsq_d;
      acc_q     <= acc_d;
      pad_q     <= pad_d;
      err_q     <= err_d;
      o_valid_q <= o_valid_d;
      o_data_q  <= o_data_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
    end
  end

  always_ff @(posedge p_clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= bus.i_data;
  end

  assign bus.o_data  = o_data_q;
  assign bus.o_valid = o_valid_q;
  assign bus.o_busy  = run || o_valid_q;
  assign bus.o_err   = err_q;

`ifdef CONV_PAD_SYNC_EN
  logic sof_q, eol_q, eof_q;

  always_ff @(posedge p_clk or negedge rst_n) begin
    if (!rst_n) begin
      sof_q <= 1'b0;
      eol_q <= 1'b0;
      eof_q <= 1'b0;
    end else begin
      sof_q <= run && (hcnt_q == '0) && (vcnt_q == '0);
      eol_q <= last_col;
      eof_q <= last_pos;
    end
  end

  assign bus.o_sof = sof_q;
  assign bus.o_eol = eol_q;
  assign bus.o_eof = eof_q;
`endif
endmodule

// File: tb/tb_conv_padding_p.sv
// Self-checking bench: two padders (PAD=1, PAD=2) driven from per-DUT input schedules,
// compared every cycle against a queue-based frame model of the padding rules.
module tb_conv_padding_p;
  localparam int DW  = 16;
  localparam int SW  = 11;
  localparam int FAW = 6;
  localparam int NC  = 1024;

  logic p_clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 p_clk = ~p_clk;

  conv_padding_p_if #(.DW(DW), .SW(SW)) bus0 ();
  conv_padding_p_if #(.DW(DW), .SW(SW)) bus1 ();

  conv_padding_p #(.DW(DW), .SW(SW), .PAD(1), .FIFO_AW(FAW)) dut0 (.p_clk(p_clk), .rst_n(rst_n), .bus(bus0));
  conv_padding_p #(.DW(DW), .SW(SW), .PAD(2), .FIFO_AW(FAW)) dut1 (.p_clk(p_clk), .rst_n(rst_n), .bus(bus1));

  bit                   sv   [2][NC];
  logic signed [DW-1:0] sd   [2][NC];
  logic signed [DW-1:0] spad [2][NC];
  logic [SW-1:0]        ssz  [2][NC];

  bit                   ev [2][NC+1];
  bit                   eb [2][NC+1];
  bit                   ee [2][NC+1];
  logic signed [DW-1:0] ed [2][NC+1];
`ifdef CONV_PAD_SYNC_EN
  bit esof [2][NC+1];
  bit eeol [2][NC+1];
  bit eeof [2][NC+1];
`endif

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input int k, input int t, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s dut%0d cycle %0d: got %0h expected %0h", tag, k, t, got, exp);
    end
  endtask

  task automatic clr(input int k);
    for (int t = 0; t < NC; t++) begin
      sv[k][t]   = 1'b0;
      sd[k][t]   = DW'($urandom);
      spad[k][t] = DW'($urandom);
      ssz[k][t]  = SW'($urandom_range(0, 7));
    end
  endtask

  // Schedules one frame for DUT k starting at cycle s; returns its last RUN cycle.
  function automatic int add_frame(int k, int s, int n, int padv, bit gaps, int stall_at,
                                   int stall_len, int extra, bit rnd, int base);
    int p = k + 1;
    int m = n + 2 * p;
    int w = s;
    int dl;
    for (int j = 0; j < n * n + extra; j++) begin
      if (j > 0) begin
        w++;
        if (j == stall_at) w += stall_len;
        if (gaps && j < n * n) begin
          dl = s + (j / n + p) * m + (j % n) + p;
          if (dl > w) w += $urandom_range(0, (dl - w > 3) ? 3 : dl - w);
        end
      end
      if (w < NC) begin
        sv[k][w] = 1'b1;
        sd[k][w] = rnd ? DW'($urandom) : DW'(base + j);
        if (j == 0) begin
          ssz[k][w]  = SW'(n);
          spad[k][w] = DW'(padv);
        end
      end
    end
    return s + m * m;
  endfunction

  task automatic run_model(input int k, input int ncyc);
    int p = k + 1;
    int rs = -1, re = -1, n = 0, m = 0, acc = 0, pos, r, c;
    bit err = 1'b0, inr, brd;
    logic signed [DW-1:0] pv = '0;
    logic signed [DW-1:0] q [$];
    for (int t = 0; t <= NC; t++) begin
      ev[k][t] = 0; eb[k][t] = 0; ee[k][t] = 0; ed[k][t] = '0;
`ifdef CONV_PAD_SYNC_EN
      esof[k][t] = 0; eeol[k][t] = 0; eeof[k][t] = 0;
`endif
    end
    for (int t = 0; t < ncyc; t++) begin
      ee[k][t] = err;
      inr = (rs >= 0) && (t > rs) && (t <= re);
      eb[k][t] = inr || ev[k][t];
      if (inr) begin
        pos = t - rs - 1;
        r = pos / m;
        c = pos % m;
        ev[k][t+1] = 1'b1;
`ifdef CONV_PAD_SYNC_EN
        esof[k][t+1] = (pos == 0);
        eeol[k][t+1] = (c == m - 1);
        eeof[k][t+1] = (pos == m * m - 1);
`endif
        brd = (r < p) || (r >= p + n) || (c < p) || (c >= p + n);
        if (brd) ed[k][t+1] = pv;
        else if (q.size() > 0) ed[k][t+1] = q.pop_front();
        else err = 1'b1;
      end
      if (sv[k][t]) begin
        if (!inr || t == re) begin
          if (ssz[k][t] != 0) begin
            rs = t; n = int'(ssz[k][t]); m = n + 2 * p; re = t + m * m;
            pv = spad[k][t];
            q.delete();
            q.push_back(sd[k][t]);
            acc = 1;
          end
        end else if (acc < n * n) begin
          q.push_back(sd[k][t]);
          acc++;
        end else begin
          err = 1'b1;
        end
      end
    end
  endtask

  task automatic check_cycle(input int t);
    chk("o_valid", 0, t, bus0.o_valid, ev[0][t]);
    chk("o_data",  0, t, bus0.o_data,  ed[0][t]);
    chk("o_busy",  0, t, bus0.o_busy,  eb[0][t]);
    chk("o_err",   0, t, bus0.o_err,   ee[0][t]);
    chk("o_valid", 1, t, bus1.o_valid, ev[1][t]);
    chk("o_data",  1, t, bus1.o_data,  ed[1][t]);
    chk("o_busy",  1, t, bus1.o_busy,  eb[1][t]);
    chk("o_err",   1, t, bus1.o_err,   ee[1][t]);
`ifdef CONV_PAD_SYNC_EN
    chk("o_sof", 0, t, bus0.o_sof, esof[0][t]);
    chk("o_eol", 0, t, bus0.o_eol, eeol[0][t]);
    chk("o_eof", 0, t, bus0.o_eof, eeof[0][t]);
    chk("o_sof", 1, t, bus1.o_sof, esof[1][t]);
    chk("o_eol", 1, t, bus1.o_eol, eeol[1][t]);
    chk("o_eof", 1, t, bus1.o_eof, eeof[1][t]);
`endif
  endtask

  // Pulses reset (checking outputs clear at once), then replays both schedules for ncyc cycles.
  task automatic run_phase(input int ncyc);
    run_model(0, ncyc);
    run_model(1, ncyc);
    bus0.i_valid = 1'b0;
    bus1.i_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_valid", 0, -1, bus0.o_valid, 0);
    chk("rst_data",  0, -1, bus0.o_data,  0);
    chk("rst_busy",  0, -1, bus0.o_busy,  0);
    chk("rst_err",   0, -1, bus0.o_err,   0);
    chk("rst_valid", 1, -1, bus1.o_valid, 0);
    chk("rst_data",  1, -1, bus1.o_data,  0);
    chk("rst_busy",  1, -1, bus1.o_busy,  0);
    chk("rst_err",   1, -1, bus1.o_err,   0);
    @(negedge p_clk);
    rst_n = 1'b1;
    @(posedge p_clk);
    #1;
    for (int t = 0; t < ncyc; t++) begin
      bus0.i_valid = sv[0][t]; bus0.i_data = sd[0][t];
      bus0.image_size = ssz[0][t]; bus0.pad_value = spad[0][t];
      bus1.i_valid = sv[1][t]; bus1.i_data = sd[1][t];
      bus1.image_size = ssz[1][t]; bus1.pad_value = spad[1][t];
      check_cycle(t);
      @(posedge p_clk);
      #1;
    end
  endtask

  initial begin
    int s, e;
    bus0.i_valid = 0; bus0.i_data = '0; bus0.image_size = '0; bus0.pad_value = '0;
    bus1.i_valid = 0; bus1.i_data = '0; bus1.image_size = '0; bus1.pad_value = '0;

    // N=3, pad 21, pixels 1..9 contiguous; an image_size=0 strobe first must be ignored
    for (int k = 0; k < 2; k++) begin
      clr(k);
      sv[k][0] = 1'b1;
      ssz[k][0] = '0;
      void'(add_frame(k, 2, 3, 21, 0, -1, 0, 0, 0, 1));
    end
    run_phase(70);

    // N=2, pad -1, pixels 10..13
    for (int k = 0; k < 2; k++) begin
      clr(k);
      void'(add_frame(k, 1, 2, -1, 0, -1, 0, 0, 0, 10));
    end
    run_phase(50);

    // N=4 with four surplus words: dropped, sticky error
    for (int k = 0; k < 2; k++) begin
      clr(k);
      void'(add_frame(k, 1, 4, 5, 0, -1, 0, 4, 0, 1));
    end
    run_phase(75);

    // N=4, input stalls after word 5 -> underflow
    for (int k = 0; k < 2; k++) begin
      clr(k);
      void'(add_frame(k, 1, 4, -7, 0, 5, 20 + 10 * k, 0, 0, 1));
    end
    run_phase(80);

    // back-to-back: N=3 then N=2 chained at the last RUN cycle
    for (int k = 0; k < 2; k++) begin
      clr(k);
      e = add_frame(k, 1, 3, 7, 0, -1, 0, 0, 0, 100);
      void'(add_frame(k, e, 2, -3, 0, -1, 0, 0, 0, 200));
    end
    run_phase(95);

    // random frames, sizes, pad values, gaps and spacing (including chained starts)
    for (int k = 0; k < 2; k++) begin
      clr(k);
      s = 1 + $urandom_range(0, 3);
      while (s < 590) begin
        e = add_frame(k, s, $urandom_range(1, 6), $urandom, 1, -1, 0, 0, 1, 0);
        s = e + $urandom_range(0, 3);
      end
    end
    run_phase(600);

    // frame cut short by reset, then a clean frame after release
    for (int k = 0; k < 2; k++) begin
      clr(k);
      void'(add_frame(k, 1, 5, 9, 0, -1, 0, 0, 0, 50));
    end
    run_phase(20);
    for (int k = 0; k < 2; k++) begin
      clr(k);
      void'(add_frame(k, 1, 3, -100, 1, -1, 0, 0, 1, 0));
    end
    run_phase(60);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/conv_padding_p.md
# conv_padding_p

Parametrised border-padding stage in front of the convolution engine. Accepts a raster-ordered N×N pixel frame of signed words and emits an (N+2·PAD)×(N+2·PAD) frame, one word per cycle. Border pixels carry a runtime pad value; interior pixels are the input frame, buffered in an internal FIFO. Adds the following over the fixed single-pixel, fixed-value padder:

- configurable border width
- configurable data width
- configurable FIFO depth
- runtime pad value
- busy and error reporting

## Interface
Parameters:
- DW, 16, pixel width (signed)
- SW, 11, width of image_size and of the internal row/column counters
- PAD, 1, border width in pixels (1..4)
- FIFO_AW, 11, FIFO address width; depth = 2^FIFO_AW, must be ≥ 3·PAD·N + PAD for the largest N used

Ports:
- p_clk  in  1  clock, all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- i_data  in  DW  input pixel, signed
- i_valid  in  1  input pixel strobe
- image_size  in  SW  N, sampled on frame start
- pad_value  in  DW  border value, sampled on frame start
- o_data  out  DW  output pixel; 0 whenever o_valid=0
- o_valid  out  1  output pixel strobe
- o_busy  out  1  frame in progress (state RUN or output pipeline non-empty)
- o_err  out  1  sticky error flag, cleared only by reset

## Operation
Define M = N + 2·PAD.

States:
- IDLE → RUN: when i_valid=1 and image_size≠0. Latch M, N and pad_value. That cycle's i_data is pixel 0 and is written to the FIFO.
- i_valid=1 with image_size=0: ignored, state stays IDLE.
- RUN → IDLE: after the counter reaches hcnt=M−1, vcnt=M−1.

Counters (in RUN):
- hcnt runs 0..M−1, then wraps to 0.
- vcnt increments on each hcnt wrap.
- Both are 0 in IDLE.

Output position (vcnt, hcnt):
- Border if vcnt<PAD, vcnt≥PAD+N, hcnt<PAD or hcnt≥PAD+N. The output is the latched pad_value.
- Interior otherwise. The FIFO is popped and the output is the popped word, so interior pixels leave in input order.

Input accounting:
- A per-frame counter counts accepted words, including pixel 0.
- Words with i_valid=1 in RUN after N² words have been accepted are dropped and set o_err.
- Words arriving while draining the output pipeline in IDLE start the next frame.

Errors:
- Underflow (interior position, FIFO empty): sets o_err, outputs 0 for that pixel, frame continues.
- Overflow (write while FIFO full): sets o_err, the word is dropped.

Other rules:
- The FIFO is internal (no vendor IP), show-ahead, and is flushed on the RUN→IDLE transition.
- The pad value is not clamped; all DW bits pass through.
- Reset mid-frame: everything returns to its reset values at once, the FIFO is emptied, and the frame is lost.

## Timing
- Reset values: o_data=0, o_valid=0, o_busy=0, o_err=0; internally state=IDLE, counters=0, FIFO empty.
- Let cycle 0 be the cycle in which the starting i_valid is sampled. Output pixel (r,c) appears with o_valid=1 in cycle 2 + r·M + c.
- Output is gap-free: exactly M² consecutive o_valid cycles per frame.
- Contiguous input (one word per cycle from cycle 0) never underflows for any N≥1 and PAD ≤ 4. Input may contain gaps, provided each word is written before the cycle its interior position is reached.
- o_busy rises in cycle 1 and falls the cycle after the last o_valid.
- A new frame may start in the cycle following the last RUN cycle. Its output follows the previous frame with no idle gap.
- No backpressure: the downstream must accept every o_valid cycle.

## Configuration
- CONV_PAD_SYNC_EN defined: adds outputs o_sof, o_eol and o_eof (1 bit each), aligned with o_valid.
  - o_sof: high for pixel (0,0).
  - o_eol: high for every c=M−1.
  - o_eof: high for pixel (M−1,M−1).
  - All reset to 0.
- CONV_PAD_SYNC_EN undefined: these ports and their logic do not exist. All other behaviour is identical.

## Test plan
- N=3, PAD=1, pad_value=21, input 1..9 contiguous → o_valid at cycles 2..26. Rows are 21×5; then 21,1,2,3,21; 21,4,5,6,21; 21,7,8,9,21; 21×5. o_err=0, o_busy low at cycle 27.
- N=2, PAD=2, pad_value=−1, input 10,11,12,13 → 36 outputs, 6×6 grid. Interior rows 2–3: −1,−1,10,11,−1,−1 and −1,−1,12,13,−1,−1; all other pixels −1.
- N=4, PAD=1, 20 consecutive valid words → first 16 padded as one frame. Words 17–20 dropped, o_err=1 and stays 1 until rst_n low.
- N=4, PAD=1, input stalls after word 5 for 20 cycles → underflow at the interior pixel after 5. That pixel is 0, o_err=1, and the frame still emits 36 pixels.
- Two back-to-back frames (N=3, then N=2 with a different pad_value) → 25 then 16 outputs with no gap. The second frame uses its own sampled size and value.
- rst_n pulsed low in mid-frame → outputs 0 immediately. The next frame after release pads correctly with no leftover data; with CONV_PAD_SYNC_EN, o_sof/o_eol/o_eof land on the correct pixels.
